// File: rtl/riscv_lsu.sv
// Load-store unit: aligns core data accesses onto a word-organised memory and stalls the core until the memory handshake completes.
// Optional misaligned-access trap enabled by defining LSU_MISALIGN_EN (adds misalign_o).
module riscv_lsu #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        core_req_i,
    input  logic        core_we_i,
    input  logic [2:0]  core_size_i,
    input  logic [31:0] core_addr_i,
    input  logic [31:0] core_wd_i,
    output logic [31:0] core_rd_o,
    output logic        core_stall_o,
    output logic        bus_err_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wd_o,
`ifdef LSU_MISALIGN_EN
    output logic        misalign_o,
`endif
    input  logic [31:0] mem_rd_i,
    input  logic        mem_ready_i
);

    localparam int unsigned CNT_W = 8;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;

    logic        is_byte;
    logic        is_half;
    logic        is_uns;
    logic [3:0]  be;
    logic [31:0] wd_rep;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_data;
    logic        misalign;
    logic        timeout;

    // Size decode, lane enables, store replication and load extraction
    always_comb begin
        is_byte = (core_size_i == 3'd0) || (core_size_i == 3'd4);
        is_half = (core_size_i == 3'd1) || (core_size_i == 3'd5);
        is_uns  = (core_size_i == 3'd4) || (core_size_i == 3'd5);
        be      = 4'b1111;
        wd_rep  = core_wd_i;
        if (is_byte) begin
            be     = 4'b0001 << core_addr_i[1:0];
            wd_rep = {4{core_wd_i[7:0]}};
        end else if (is_half) begin
            be     = core_addr_i[1] ? 4'b1100 : 4'b0011;
            wd_rep = {2{core_wd_i[15:0]}};
        end

        case (core_addr_i[1:0])
            2'd0:    ld_byte = mem_rd_i[7:0];
            2'd1:    ld_byte = mem_rd_i[15:8];
            2'd2:    ld_byte = mem_rd_i[23:16];
            default: ld_byte = mem_rd_i[31:24];
        endcase
        ld_half = core_addr_i[1] ? mem_rd_i[31:16] : mem_rd_i[15:0];

        ld_data = mem_rd_i;
        if (is_byte) begin
            ld_data = {{24{ld_byte[7] & ~is_uns}}, ld_byte};
        end else if (is_half) begin
            ld_data = {{16{ld_half[15] & ~is_uns}}, ld_half};
        end
    end

`ifdef LSU_MISALIGN_EN
    assign misalign = (state == IDLE) && core_req_i &&
                      ((is_half && core_addr_i[0]) ||
                       ((core_size_i == 3'd2) && (core_addr_i[1:0] != 2'd0)));
    assign misalign_o = misalign;
`else
    assign misalign = 1'b0;
`endif

    assign timeout = (state == BUSY) && core_req_i && !mem_ready_i && (cnt == CNT_LAST);

    // Handshake outputs follow the live request; the bus payload is zero whenever no request is issued
    always_comb begin
        mem_req_o    = 1'b0;
        core_stall_o = 1'b0;
        core_rd_o    = 32'd0;
        mem_we_o     = 1'b0;
        mem_be_o     = 4'd0;
        mem_addr_o   = 32'd0;
        mem_wd_o     = 32'd0;
        case (state)
            IDLE: begin
                if (core_req_i && !misalign) begin
                    mem_req_o    = 1'b1;
                    core_stall_o = 1'b1;
                end
            end
            BUSY: begin
                if (core_req_i) begin
                    if (mem_ready_i) begin
                        mem_req_o = 1'b1;
                        core_rd_o = ld_data;
                    end else if (!timeout) begin
                        mem_req_o    = 1'b1;
                        core_stall_o = 1'b1;
                    end
                end
            end
            default: ;
        endcase
        if (mem_req_o) begin
            mem_we_o   = core_we_i;
            mem_be_o   = be;
            mem_addr_o = {core_addr_i[31:2], 2'b00};
            mem_wd_o   = wd_rep;
        end
    end

    // State, timeout counter and the registered abort pulse
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state     <= IDLE;
            cnt       <= '0;
            bus_err_o <= 1'b0;
        end else begin
            bus_err_o <= timeout;
            case (state)
                IDLE: begin
                    if (core_req_i && !misalign) begin
                        state <= BUSY;
                        cnt   <= '0;
                    end
                end
                BUSY: begin
                    if (!core_req_i || mem_ready_i || timeout) begin
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
